// File: rtl/bm_if_expand_pkg.sv
// Shared constants and state encoding for the conditional-capture transmit driver.
package bm_if_expand_pkg;

  localparam int unsigned BM_BITS = 2;
  localparam int unsigned HC_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SEND  = 2'b01,
    ST_HOLD  = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

endpackage

// File: rtl/bm_if_expand_hold_cnt.sv
// Loadable down-counter timing the hold window after each load strobe.
module bm_if_expand_hold_cnt
  import bm_if_expand_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic [HC_W-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [HC_W-1:0] cnt_q, cnt_d;

  // Load takes priority over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bm_if_expand_tx.sv
// Transmit driver: accepts symbols over valid/ready and emits load strobe,
// hold window and clear pulses toward a conditional-capture receiver.
module bm_if_expand_tx
  import bm_if_expand_pkg::*;
#(
  parameter int unsigned BITS     = BM_BITS,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [BITS-1:0]  sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             clear_req,
  output logic [BITS-1:0]  a_out,
  output logic [BITS-1:0]  b_out,
  output logic             c_out,
  output logic             d_out,
  output logic             busy,
  output logic [CNT_W-1:0] sent_count
);

  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYC - 1);

  state_t           state_q, state_d;
  logic             clr_pend_q, clr_pend_d;
  logic [BITS-1:0]  a_q, a_d, b_q, b_d;
  logic             c_q, c_d, d_q, d_d, busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hc_load, hc_dec, hc_zero;
  logic             pend_now;

  bm_if_expand_hold_cnt u_hold_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (hc_load),
    .load_val_i (HOLD_LOAD),
    .dec_i      (hc_dec),
    .zero_o     (hc_zero)
  );

  // A request arriving on the last SEND/HOLD cycle still merges into the
  // pending pulse so the clear follows the hold window without an IDLE gap.
  assign pend_now  = clr_pend_q | clear_req;
  assign sym_ready = (state_q == ST_IDLE) && !clear_req && !clr_pend_q && reset_n;

  // Next-state logic; registered outputs are decoded from the next state so
  // they line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    hc_load    = 1'b0;
    hc_dec     = 1'b0;
    clr_pend_d = clr_pend_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = 1'b1;
    d_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_req || clr_pend_q) begin
          state_d = ST_CLEAR;
        end else if (sym_valid) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (clear_req) clr_pend_d = 1'b1;
        if (HOLD_CYC > 0) begin
          hc_load = 1'b1;
          state_d = ST_HOLD;
        end else if (pend_now) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (clear_req) clr_pend_d = 1'b1;
        if (hc_zero) begin
          state_d = pend_now ? ST_CLEAR : ST_IDLE;
        end else begin
          hc_dec = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_IDLE: begin
        a_d = '0;
        b_d = '0;
      end
      ST_SEND: begin
        a_d   = sym_in;
        b_d   = '1;
        d_d   = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
      ST_HOLD: begin
      end
      ST_CLEAR: begin
        a_d        = '0;
        b_d        = '0;
        c_d        = 1'b0;
        clr_pend_d = 1'b0;
      end
      default: begin
      end
    endcase

    busy_d = (state_d != ST_IDLE) || clr_pend_d;
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      clr_pend_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      d_q        <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign c_out      = c_q;
  assign d_out      = d_q;
  assign busy       = busy_q;
  assign sent_count = cnt_q;

endmodule

// File: tb/tb_bm_if_expand_tx.sv
// Directed bench for bm_if_expand_tx at default parameters (BITS=2, HOLD_CYC=2, CNT_W=4).
module tb_bm_if_expand_tx;

  logic       clock;
  logic       reset_n;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       clear_req;
  logic [1:0] a_out;
  logic [1:0] b_out;
  logic       c_out;
  logic       d_out;
  logic       busy;
  logic [3:0] sent_count;

  int n_cmp = 0;
  int n_err = 0;

  bm_if_expand_tx #(.BITS(2), .HOLD_CYC(2), .CNT_W(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .clear_req  (clear_req),
    .a_out      (a_out),
    .b_out      (b_out),
    .c_out      (c_out),
    .d_out      (d_out),
    .busy       (busy),
    .sent_count (sent_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    reset_n = 1'b0; sym_in = '0; sym_valid = 1'b0; clear_req = 1'b0;
    step();
    step();
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b00_00_0_0) begin n_err++; $display("FAIL reset_outs: got %b exp %b", obs, 6'b00_00_0_0); end
    n_cmp++;
    if (sent_count !== 4'd0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_cnt_busy: got cnt=%0d busy=%b exp 0/0", sent_count, busy); end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (sym_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", sym_ready); end
    n_cmp++;
    if (c_out !== 1'b0) begin n_err++; $display("FAIL reset_first_c: got %b exp 0", c_out); end
    step();
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b00_00_1_0) begin n_err++; $display("FAIL reset_idle_outs: got %b exp %b", obs, 6'b00_00_1_0); end
  endtask

  task automatic test_single();
    logic [5:0] obs;
    sym_in = 2'b10; sym_valid = 1'b1;
    #1;
    n_cmp++;
    if (sym_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b exp 1", sym_ready); end
    step();
    sym_valid = 1'b0;
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b10_11_1_1) begin n_err++; $display("FAIL single_send: got %b exp %b", obs, 6'b10_11_1_1); end
    n_cmp++;
    if (sent_count !== 4'd1 || busy !== 1'b1) begin n_err++; $display("FAIL single_cnt_busy: got cnt=%0d busy=%b exp 1/1", sent_count, busy); end
    for (int i = 0; i < 2; i++) begin
      step();
      obs = {a_out, b_out, c_out, d_out};
      n_cmp++;
      if (obs !== 6'b10_11_1_0) begin n_err++; $display("FAIL single_hold%0d: got %b exp %b", i, obs, 6'b10_11_1_0); end
    end
    step();
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b00_00_1_0 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b busy=%b exp %b busy=0", obs, busy, 6'b00_00_1_0); end
    n_cmp++;
    if (sent_count !== 4'd1) begin n_err++; $display("FAIL single_cnt_end: got %0d exp 1", sent_count); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_sym [3];
    int k;
    int last;
    logic prev_d;
    exp_sym[0] = 2'b01; exp_sym[1] = 2'b11; exp_sym[2] = 2'b00;
    do_reset();
    k = 0; last = 0; prev_d = 1'b0;
    sym_in = exp_sym[0]; sym_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && k < 3; cyc++) begin
      step();
      if (d_out === 1'b1) begin
        n_cmp++;
        if (a_out !== exp_sym[k] || c_out !== 1'b1 || prev_d === 1'b1) begin
          n_err++; $display("FAIL b2b_pulse%0d: got a=%b c=%b prev_d=%b exp a=%b c=1 prev_d=0", k, a_out, c_out, prev_d, exp_sym[k]);
        end
        if (k > 0) begin
          n_cmp++;
          if (cyc - last !== 4) begin n_err++; $display("FAIL b2b_period%0d: got %0d exp 4", k, cyc - last); end
        end
        last = cyc;
        k++;
        if (k < 3) sym_in = exp_sym[k];
        else sym_valid = 1'b0;
      end
      prev_d = d_out;
    end
    n_cmp++;
    if (k !== 3) begin n_err++; $display("FAIL b2b_timeout: got %0d pulses exp 3", k); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (d_out !== 1'b0) begin n_err++; $display("FAIL b2b_tail%0d: got d=%b exp 0", i, d_out); end
    end
    n_cmp++;
    if (sent_count !== 4'd3 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_cnt: got cnt=%0d busy=%b exp 3/0", sent_count, busy); end
  endtask

  task automatic test_clear_tie();
    logic [5:0] obs;
    clear_req = 1'b1; sym_valid = 1'b1; sym_in = 2'b11;
    #1;
    n_cmp++;
    if (sym_ready !== 1'b0) begin n_err++; $display("FAIL tie_ready_idle: got %b exp 0", sym_ready); end
    step();
    clear_req = 1'b0;
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b00_00_0_0 || busy !== 1'b1) begin n_err++; $display("FAIL tie_clear: got %b busy=%b exp %b busy=1", obs, busy, 6'b00_00_0_0); end
    #1;
    n_cmp++;
    if (sym_ready !== 1'b0) begin n_err++; $display("FAIL tie_ready_clear: got %b exp 0", sym_ready); end
    step();
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b00_00_1_0 || sym_ready !== 1'b1) begin n_err++; $display("FAIL tie_idle: got %b rdy=%b exp %b rdy=1", obs, sym_ready, 6'b00_00_1_0); end
    step();
    sym_valid = 1'b0;
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b11_11_1_1 || sent_count !== 4'd4) begin n_err++; $display("FAIL tie_send: got %b cnt=%0d exp %b cnt=4", obs, sent_count, 6'b11_11_1_1); end
    step(); step(); step();
    n_cmp++;
    if (busy !== 1'b0 || c_out !== 1'b1) begin n_err++; $display("FAIL tie_end: got busy=%b c=%b exp 0/1", busy, c_out); end
  endtask

  task automatic test_clear_in_hold();
    logic [5:0] obs;
    sym_in = 2'b01; sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    clear_req = 1'b1;
    n_cmp++;
    if (d_out !== 1'b1 || sent_count !== 4'd5) begin n_err++; $display("FAIL hclr_send: got d=%b cnt=%0d exp 1/5", d_out, sent_count); end
    step();
    clear_req = 1'b0;
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b01_11_1_0 || busy !== 1'b1) begin n_err++; $display("FAIL hclr_hold1: got %b busy=%b exp %b busy=1", obs, busy, 6'b01_11_1_0); end
    step();
    clear_req = 1'b1;
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b01_11_1_0 || busy !== 1'b1) begin n_err++; $display("FAIL hclr_hold2: got %b busy=%b exp %b busy=1", obs, busy, 6'b01_11_1_0); end
    step();
    clear_req = 1'b0;
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b00_00_0_0 || busy !== 1'b1) begin n_err++; $display("FAIL hclr_clear: got %b busy=%b exp %b busy=1", obs, busy, 6'b00_00_0_0); end
    step();
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b00_00_1_0 || busy !== 1'b0) begin n_err++; $display("FAIL hclr_idle: got %b busy=%b exp %b busy=0", obs, busy, 6'b00_00_1_0); end
    step();
    n_cmp++;
    if (c_out !== 1'b1) begin n_err++; $display("FAIL hclr_single: got c=%b exp 1", c_out); end
  endtask

  task automatic test_wrap_and_reset();
    logic [5:0] obs;
    int k;
    do_reset();
    k = 0;
    sym_in = 2'b10; sym_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && k < 17; cyc++) begin
      step();
      if (d_out === 1'b1) begin
        k++;
        if (k == 16) begin
          n_cmp++;
          if (sent_count !== 4'd0) begin n_err++; $display("FAIL wrap_16: got %0d exp 0", sent_count); end
        end
        if (k == 17) sym_valid = 1'b0;
      end
    end
    n_cmp++;
    if (k !== 17 || sent_count !== 4'd1) begin n_err++; $display("FAIL wrap_17: got pulses=%0d cnt=%0d exp 17/1", k, sent_count); end
    step();
    n_cmp++;
    if (d_out !== 1'b0 || c_out !== 1'b1) begin n_err++; $display("FAIL wrap_hold: got d=%b c=%b exp 0/1", d_out, c_out); end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    obs = {a_out, b_out, c_out, d_out};
    n_cmp++;
    if (obs !== 6'b00_00_0_0 || busy !== 1'b0 || sent_count !== 4'd0) begin
      n_err++; $display("FAIL midreset: got %b busy=%b cnt=%0d exp %b busy=0 cnt=0", obs, busy, sent_count, 6'b00_00_0_0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {a_out, b_out, c_out, d_out};
      n_cmp++;
      if (obs !== 6'b00_00_1_0 || sent_count !== 4'd0) begin n_err++; $display("FAIL postreset%0d: got %b cnt=%0d exp %b cnt=0", i, obs, sent_count, 6'b00_00_1_0); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clear_tie();
    test_clear_in_hold();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bm_if_expand_tx.md
Name: bm_if_expand_tx

Overview:
Transmit-side driver for the conditional-capture register protocol used by the if-collapse micro benchmarks. The receiver is modelled as follows:
- c=0: clears its data register.
- c=1, d=1: loads a&b.
- c=1, d=0: holds.

This block accepts symbols over a valid/ready handshake, emits each one as a single-cycle load strobe followed by a programmable hold window, and issues clear pulses on request. It sits in front of a bm_if_collapse-style receiver in the micro regression suite.

Parameters:
BITS, 2, data width of symbol and a_out/b_out.
HOLD_CYC, 2, hold cycles (c=1,d=0) after each load strobe; legal range 0..15.
CNT_W, 4, width of sent_count.

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock.
sym_in  input  BITS  symbol to transmit.
sym_valid  input  1  sym_in valid.
sym_ready  output  1  block can accept sym_in this cycle.
clear_req  input  1  request one clear pulse to receiver (level, sampled each cycle).
a_out  output  BITS  receiver a operand.
b_out  output  BITS  receiver b operand.
c_out  output  1  receiver enable; 0 = clear.
d_out  output  1  receiver load strobe.
busy  output  1  state != IDLE or clear pending.
sent_count  output  CNT_W  number of load strobes issued, modulo 2^CNT_W.

Behaviour:
- Outputs and ports:
  - All outputs except sym_ready are registered.
  - sym_ready is combinational: (state==IDLE) && !clear_req && !clr_pend && reset_n.
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, a_out=0, b_out=0, c_out=0, d_out=0, sent_count=0, clr_pend=0, hold_cnt=0, busy=0.
  - First cycle out of reset drives c=0 (receiver cleared); following cycle drives IDLE values.
  - Reset mid-SEND/HOLD/CLEAR aborts immediately; the accepted symbol is dropped, not retried.
- State IDLE:
  - Drives c_out=1, d_out=0, a_out=0, b_out=0.
  - If clear_req: go to CLEAR; the symbol is not accepted, so clear wins a tie with sym_valid.
  - Else if sym_valid: accept, latch sym_in, go to SEND.
- State SEND (exactly 1 cycle):
  - Drives a_out=symbol, b_out=all-ones (receiver a&b == symbol), c_out=1, d_out=1.
  - sent_count increments on entry and wraps 2^CNT_W-1 -> 0.
  - Exit:
    - HOLD_CYC>0: load hold_cnt=HOLD_CYC-1 and go to HOLD.
    - HOLD_CYC==0 and clr_pend: go to CLEAR.
    - HOLD_CYC==0 otherwise: go to IDLE.
- State HOLD:
  - Drives c_out=1, d_out=0; a_out/b_out keep SEND values.
  - hold_cnt decrements each cycle.
  - When hold_cnt==0: go to CLEAR if clr_pend, else IDLE.
- State CLEAR (exactly 1 cycle):
  - Drives c_out=0, d_out=0, a_out=0, b_out=0.
  - clr_pend cleared on entry; next state IDLE.
- Clear requests while busy:
  - clear_req seen in SEND/HOLD sets clr_pend; multiple requests merge into one pulse.
  - clear_req asserted in CLEAR is ignored; a new request is needed after return to IDLE.
- Latency and throughput:
  - Handshake at edge N -> d_out=1 in the cycle after N.
  - Back-to-back period is HOLD_CYC+2 cycles; 4 at default.
- Output invariant: d_out=1 implies c_out=1; d_out is never high for two consecutive cycles.

Decomposition:
- Package bm_if_expand_pkg:
  - BITS default constant.
  - State encoding: IDLE=2'b00, SEND=2'b01, HOLD=2'b10, CLEAR=2'b11.
  - Hold-counter width constant HC_W=4.
- One sub-module, bm_if_expand_hold_cnt:
  - Loadable down-counter with load, dec and zero outputs.
  - Same clock/reset_n; resets to 0.

Test Plan:
- Reset: reset_n=0 for 2 cycles, then 1 -> c_out=0 first cycle after reset, then c=1/d=0; sent_count=0; sym_ready=1.
- Single send, sym_in=2'b10, HOLD_CYC=2 -> cycle after accept: a=10, b=11, c=1, d=1; next 2 cycles c=1, d=0; then IDLE; sent_count=1.
- Back-to-back sym_valid held high with sym_in 01, 11, 00 -> d_out pulses exactly 4 cycles apart; a_out=01, 11, 00 in order; sent_count=3.
- clear_req and sym_valid together in IDLE -> one CLEAR cycle (c=0, a=0), symbol accepted only on the following IDLE cycle.
- clear_req pulsed twice during HOLD -> exactly one CLEAR cycle immediately after HOLD ends, no intervening IDLE; busy high throughout.
- 17 sends with CNT_W=4 -> sent_count wraps to 1; reset asserted during HOLD -> outputs at reset values next cycle, no extra d_out pulse.
